fpu_op_sequencer: RTL

Command front-end sitting directly upstream of the FPU AXI4 master. It buffers FP operation requests (opcode plus two IEEE-754 single operands) in a FIFO and issues them one at a time to the master over a valid/ready issue port. It waits for the master's read-back completion and returns the result, in order, over a valid/ready response port. It also screens illegal opcodes and enforces a completion timeout.

---
 rtl/fpu_op_sequencer_if.sv | 54 +++++
 rtl/fpu_op_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fpu_op_sequencer_if.sv
// Bundle of command, issue, completion and response signals between
// the FPU op sequencer (slave side) and its surrounding logic (master).
interface fpu_op_sequencer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_opcode;
    logic [31:0]   cmd_op1;
    logic [31:0]   cmd_op2;

    logic          iss_valid;
    logic          iss_ready;
    logic [7:0]    iss_opcode;
    logic [31:0]   iss_op1;
    logic [31:0]   iss_op2;

    logic          cpl_valid;
    logic [31:0]   cpl_data;
    logic [1:0]    cpl_resp;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_data;
    logic [1:0]    rsp_resp;
    logic [7:0]    rsp_opcode;

    logic          busy;
    logic [CW-1:0] fifo_count;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_op1, cmd_op2,
        input  iss_ready,
        input  cpl_valid, cpl_data, cpl_resp,
        input  rsp_ready,
        output cmd_ready,
        output iss_valid, iss_opcode, iss_op1, iss_op2,
        output rsp_valid, rsp_data, rsp_resp, rsp_opcode,
        output busy, fifo_count
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_op1, cmd_op2,
        output iss_ready,
        output cpl_valid, cpl_data, cpl_resp,
        output rsp_ready,
        input  cmd_ready,
        input  iss_valid, iss_opcode, iss_op1, iss_op2,
        input  rsp_valid, rsp_data, rsp_resp, rsp_opcode,
        input  busy, fifo_count
    );
endinterface

// File: rtl/fpu_op_sequencer.sv
// FPU op sequencer: buffers FP commands, issues one at a time to the
// AXI4 master, and returns results in order with opcode/timeout screening.
module fpu_op_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    fpu_op_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          iss_valid_q, iss_valid_d;
    logic [7:0]    iss_opcode_q, iss_opcode_d;
    logic [31:0]   iss_op1_q, iss_op1_d;
    logic [31:0]   iss_op2_q, iss_op2_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic [1:0]    rsp_resp_q, rsp_resp_d;
    logic [7:0]    rsp_opcode_q, rsp_opcode_d;
    logic [15:0]   tmo_q, tmo_d;
    logic [71:0]   mem_q [DEPTH];
    logic [71:0]   head;
    logic          push;
    logic          pop;

    assign push = bus.cmd_valid & cmd_ready_q;
    assign head = mem_q[rd_ptr_q];

    // Sequencing FSM: pop/screen, issue, wait for completion, respond
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        iss_valid_d  = iss_valid_q;
        iss_opcode_d = iss_opcode_q;
        iss_op1_d    = iss_op1_q;
        iss_op2_d    = iss_op2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_resp_d   = rsp_resp_q;
        rsp_opcode_d = rsp_opcode_q;
        tmo_d        = tmo_q;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop          = 1'b1;
                    rsp_opcode_d = head[71:64];
                    if (head[71:64] <= 8'd2) begin
                        iss_opcode_d = head[71:64];
                        iss_op1_d    = head[63:32];
                        iss_op2_d    = head[31:0];
                        state_d      = ISSUE;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_resp_d  = 2'b11;
                        state_d     = RESP;
                    end
                end
            end
            ISSUE: begin
                iss_valid_d = 1'b1;
                if (iss_valid_q && bus.iss_ready) begin
                    iss_valid_d = 1'b0;
                    tmo_d       = '0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                tmo_d = tmo_q + 16'd1;
                if (bus.cpl_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.cpl_data;
                    rsp_resp_d  = (bus.cpl_resp != 2'b00)
                                ? 2'b11 : 2'b00;
                    state_d     = RESP;
                end else if (tmo_q == 16'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_resp_d  = 2'b10;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointers, occupancy and the registered accept flag
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        cmd_ready_d = (count_d != CW'(DEPTH));
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cmd_ready_q  <= 1'b1;
            iss_valid_q  <= 1'b0;
            iss_opcode_q <= '0;
            iss_op1_q    <= '0;
            iss_op2_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_resp_q   <= '0;
            rsp_opcode_q <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            cmd_ready_q  <= cmd_ready_d;
            iss_valid_q  <= iss_valid_d;
            iss_opcode_q <= iss_opcode_d;
            iss_op1_q    <= iss_op1_d;
            iss_op2_q    <= iss_op2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_resp_q   <= rsp_resp_d;
            rsp_opcode_q <= rsp_opcode_d;
            tmo_q        <= tmo_d;
        end
    end

    // Command storage; occupancy gates every read, so no reset needed
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cmd_opcode, bus.cmd_op1, bus.cmd_op2};
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.iss_valid  = iss_valid_q;
    assign bus.iss_opcode = iss_opcode_q;
    assign bus.iss_op1    = iss_op1_q;
    assign bus.iss_op2    = iss_op2_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_resp   = rsp_resp_q;
    assign bus.rsp_opcode = rsp_opcode_q;
    assign bus.busy       = (state_q != IDLE) || (count_q != '0);
    assign bus.fifo_count = count_q;
endmodule
